// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared definitions for the change dispenser: one-hot FSM state encoding
//   and the value of each coin type in 5-cent units.
//   No ports (package).
package change_dispenser_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_SEL   = 5'b00010,
      ST_EJECT = 5'b00100,
      ST_GAP   = 5'b01000,
      ST_FIN   = 5'b10000
   } state_t;

   localparam int COIN_NICKEL_UNITS = 1;
   localparam int COIN_DIME_UNITS   = 2;

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Bundles the refund request handshake, the hopper eject/ack handshake,
//   the refill pulses and the status outputs of the change dispenser.
//   Modports:
//     master : requester / hopper side (drives refund request, ack, refills)
//     slave  : the dispenser itself
//   Signals:
//     refund_valid/refund_units/refund_ready : refund request handshake
//     nickel_eject/dime_eject/eject_ack      : one-coin eject handshake
//     refill_nickels/refill_dimes            : 1-cycle refill pulses
//     nickel_count/dime_count                : hopper inventory
//     paid_units/done/short/jam              : payout result
interface change_dispenser_if #(
   parameter int UNIT_W = 4,
   parameter int CNT_W  = 8
);
   logic              refund_valid;
   logic [UNIT_W-1:0] refund_units;
   logic              refund_ready;
   logic              nickel_eject;
   logic              dime_eject;
   logic              eject_ack;
   logic              refill_nickels;
   logic              refill_dimes;
   logic [CNT_W-1:0]  nickel_count;
   logic [CNT_W-1:0]  dime_count;
   logic [UNIT_W-1:0] paid_units;
   logic              done;
   logic              short;
   logic              jam;

   modport master (
      output refund_valid, refund_units, eject_ack, refill_nickels, refill_dimes,
      input  refund_ready, nickel_eject, dime_eject, nickel_count, dime_count,
             paid_units, done, short, jam
   );

   modport slave (
      input  refund_valid, refund_units, eject_ack, refill_nickels, refill_dimes,
      output refund_ready, nickel_eject, dime_eject, nickel_count, dime_count,
             paid_units, done, short, jam
   );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// coin_inventory
//   Saturating inventory counter for one coin type. A refill adds INC, a
//   take removes one coin; both in the same cycle apply together. The result
//   saturates at the counter maximum and never wraps below zero.
//   Ports:
//     clock   in  system clock, rising edge
//     reset_n in  synchronous active-low reset (count <= INIT)
//     refill  in  add INC this cycle
//     take    in  remove one coin this cycle
//     count   out current coin count (registered)
module coin_inventory #(
   parameter int CNT_W = 8,
   parameter int INIT  = 20,
   parameter int INC   = 10
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             refill,
   input  logic             take,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W:0] MAX_CNT = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W:0] INC_AMT = (CNT_W+1)'(INC);
   localparam logic [CNT_W:0] ONE     = (CNT_W+1)'(1);

   logic [CNT_W:0] up;
   logic [CNT_W:0] nxt;

   // One extra bit of headroom so the refill sum can be compared against
   // the maximum before truncation.
   always_comb begin
      up  = {1'b0, count} + (refill ? INC_AMT : '0);
      nxt = up;
      if (take && (up != '0)) nxt = up - ONE;
      if (nxt > MAX_CNT)      nxt = MAX_CNT;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) count <= CNT_W'(INIT);
      else          count <= nxt[CNT_W-1:0];
   end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out change owed as dimes and nickels through an eject/ack handshake
//   with the coin hopper. Greedy payout (dimes first, never overpaying),
//   tracks hopper inventory, and reports short or jammed payouts.
//   Ports:
//     clock   in  system clock, rising edge
//     reset_n in  synchronous active-low reset
//     bus     slave modport of change_dispenser_if (request, hopper, status)
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int UNIT_W       = 4,
   parameter int CNT_W        = 8,
   parameter int INIT_NICKELS = 20,
   parameter int INIT_DIMES   = 20,
   parameter int REFILL_QTY   = 10,
   parameter int ACK_TIMEOUT  = 64
) (
   input  logic               clock,
   input  logic               reset_n,
   change_dispenser_if.slave  bus
);

   localparam int                TMR_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [UNIT_W-1:0] DIME_U   = UNIT_W'(COIN_DIME_UNITS);
   localparam logic [UNIT_W-1:0] NICKEL_U = UNIT_W'(COIN_NICKEL_UNITS);

   state_t            state;
   logic [UNIT_W-1:0] remaining;
   logic [UNIT_W-1:0] paid;
   logic              coin_dime;
   logic [TMR_W-1:0]  timer;
   logic              nickel_eject;
   logic              dime_eject;
   logic              done;
   logic              short;
   logic              jam;
   logic [CNT_W-1:0]  nickel_cnt;
   logic [CNT_W-1:0]  dime_cnt;
   logic              ack_take;

   // An ack only counts while a coin is actually being ejected.
   assign ack_take = (state == ST_EJECT) && bus.eject_ack;

   coin_inventory #(
      .CNT_W (CNT_W),
      .INIT  (INIT_NICKELS),
      .INC   (REFILL_QTY)
   ) u_nickels (
      .clock   (clock),
      .reset_n (reset_n),
      .refill  (bus.refill_nickels),
      .take    (ack_take && !coin_dime),
      .count   (nickel_cnt)
   );

   coin_inventory #(
      .CNT_W (CNT_W),
      .INIT  (INIT_DIMES),
      .INC   (REFILL_QTY)
   ) u_dimes (
      .clock   (clock),
      .reset_n (reset_n),
      .refill  (bus.refill_dimes),
      .take    (ack_take && coin_dime),
      .count   (dime_cnt)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         remaining    <= '0;
         paid         <= '0;
         coin_dime    <= 1'b0;
         timer        <= '0;
         nickel_eject <= 1'b0;
         dime_eject   <= 1'b0;
         done         <= 1'b0;
         short        <= 1'b0;
         jam          <= 1'b0;
      end else begin
         // done/short/jam are single-cycle pulses visible in FIN.
         done  <= 1'b0;
         short <= 1'b0;
         jam   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.refund_valid) begin
                  remaining <= bus.refund_units;
                  paid      <= '0;
                  state     <= ST_SEL;
               end
            end
            ST_SEL: begin
               timer <= '0;
               if ((remaining >= DIME_U) && (dime_cnt != '0)) begin
                  coin_dime  <= 1'b1;
                  dime_eject <= 1'b1;
                  state      <= ST_EJECT;
               end else if ((remaining >= NICKEL_U) && (nickel_cnt != '0)) begin
                  coin_dime    <= 1'b0;
                  nickel_eject <= 1'b1;
                  state        <= ST_EJECT;
               end else begin
                  // Nothing payable left: short if any units remain owed.
                  done  <= 1'b1;
                  short <= (remaining != '0);
                  state <= ST_FIN;
               end
            end
            ST_EJECT: begin
               if (bus.eject_ack) begin
                  nickel_eject <= 1'b0;
                  dime_eject   <= 1'b0;
                  remaining    <= remaining - (coin_dime ? DIME_U : NICKEL_U);
                  paid         <= paid + (coin_dime ? DIME_U : NICKEL_U);
                  state        <= ST_GAP;
               end else if (timer == TMR_LAST) begin
                  nickel_eject <= 1'b0;
                  dime_eject   <= 1'b0;
                  done         <= 1'b1;
                  short        <= 1'b1;
                  jam          <= 1'b1;
                  state        <= ST_FIN;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_GAP: state <= ST_SEL;
            ST_FIN: state <= ST_IDLE;
            default: begin
               nickel_eject <= 1'b0;
               dime_eject   <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.refund_ready = (state == ST_IDLE);
   assign bus.nickel_eject = nickel_eject;
   assign bus.dime_eject   = dime_eject;
   assign bus.nickel_count = nickel_cnt;
   assign bus.dime_count   = dime_cnt;
   assign bus.paid_units   = paid;
   assign bus.done         = done;
   assign bus.short        = short;
   assign bus.jam          = jam;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Scoreboard bench for change_dispenser. Each refund request pushes its
//   expected coin sequence and payout result into queues; a monitor process
//   pops and compares on every eject rising edge and every done pulse.
//   Ports: none (top-level bench).
module tb_change_dispenser;

   logic clock;
   logic reset_n;
   bit   ack_en;

   change_dispenser_if #(.UNIT_W(4), .CNT_W(8)) bus ();

   change_dispenser dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int paid;
      bit sh;
      bit jm;
   } res_t;

   bit   exp_coin[$];   // 1 = dime, 0 = nickel
   res_t exp_res[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Hopper model: acks in the first cycle an eject is seen, when enabled.
   initial begin
      bus.eject_ack = 1'b0;
      forever begin
         @(negedge clock);
         if (ack_en && !bus.eject_ack && (bus.nickel_eject || bus.dime_eject))
            bus.eject_ack = 1'b1;
         else
            bus.eject_ack = 1'b0;
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit   prev_n;
      bit   prev_d;
      bit   c;
      res_t e;
      prev_n = 1'b0;
      prev_d = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.nickel_eject && bus.dime_eject)
            check("eject_exclusive", 1, 0);
         if ((bus.nickel_eject && !prev_n) || (bus.dime_eject && !prev_d)) begin
            if (exp_coin.size() == 0) begin
               check("unexpected_eject", 1, 0);
            end else begin
               c = exp_coin.pop_front();
               check("coin_is_dime", int'(bus.dime_eject), int'(c));
            end
         end
         if (bus.done) begin
            if (exp_res.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = exp_res.pop_front();
               check("paid_units", int'(bus.paid_units), e.paid);
               check("short", int'(bus.short), int'(e.sh));
               check("jam", int'(bus.jam), int'(e.jm));
               check("coins_left", exp_coin.size(), 0);
               exp_coin.delete();
            end
         end
         prev_n = bus.nickel_eject;
         prev_d = bus.dime_eject;
      end
   end

   // Issue one refund; coins is a string of 'D'/'N' in expected eject order.
   task automatic issue(input int units, input string coins, input int paid,
                        input bit sh, input bit jm);
      res_t r;
      int   w;
      w = 0;
      while (!bus.refund_ready && w < 200) begin
         @(negedge clock);
         w++;
      end
      if (!bus.refund_ready) check("ready_timeout", 0, 1);
      for (int i = 0; i < coins.len(); i++) exp_coin.push_back(coins[i] == "D");
      r.paid = paid;
      r.sh   = sh;
      r.jm   = jm;
      exp_res.push_back(r);
      bus.refund_valid = 1'b1;
      bus.refund_units = 4'(units);
      @(negedge clock);
      bus.refund_valid = 1'b0;
      bus.refund_units = '0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && exp_res.size() != 0; i++) @(negedge clock);
      if (exp_res.size() != 0) begin
         check("done_timeout", 0, 1);
         exp_res.delete();
         exp_coin.delete();
      end
   endtask

   task automatic wait_dime_eject();
      for (int i = 0; i < 20 && !bus.dime_eject; i++) @(negedge clock);
      if (!bus.dime_eject) check("dime_eject_timeout", 0, 1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      exp_res.delete();
      exp_coin.delete();
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      int cnt;
      reset_n            = 1'b0;
      ack_en             = 1'b1;
      bus.refund_valid   = 1'b0;
      bus.refund_units   = '0;
      bus.refill_nickels = 1'b0;
      bus.refill_dimes   = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Reset state
      check("rst_nickels", int'(bus.nickel_count), 20);
      check("rst_dimes", int'(bus.dime_count), 20);
      check("rst_nickel_eject", int'(bus.nickel_eject), 0);
      check("rst_dime_eject", int'(bus.dime_eject), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_ready", int'(bus.refund_ready), 1);
      check("rst_paid", int'(bus.paid_units), 0);

      // 15c: dime then nickel
      issue(3, "DN", 3, 1'b0, 1'b0);
      wait_idle();
      check("t2_nickels", int'(bus.nickel_count), 19);
      check("t2_dimes", int'(bus.dime_count), 19);

      // Drain all dimes, then 20c must come out as four nickels
      for (int i = 0; i < 19; i++) begin
         issue(2, "D", 2, 1'b0, 1'b0);
         wait_idle();
      end
      check("t3_dimes", int'(bus.dime_count), 0);
      issue(4, "NNNN", 4, 1'b0, 1'b0);
      wait_idle();
      check("t3_nickels", int'(bus.nickel_count), 15);

      // Drain nickels, give some dimes: 5c cannot be paid without overpaying
      for (int i = 0; i < 15; i++) begin
         issue(1, "N", 1, 1'b0, 1'b0);
         wait_idle();
      end
      check("t4_nickels", int'(bus.nickel_count), 0);
      bus.refill_dimes = 1'b1;
      @(negedge clock);
      bus.refill_dimes = 1'b0;
      @(negedge clock);
      check("t4_dimes_refilled", int'(bus.dime_count), 10);
      issue(1, "", 0, 1'b1, 1'b0);
      wait_idle();
      check("t4_dimes_kept", int'(bus.dime_count), 10);
      issue(3, "D", 2, 1'b1, 1'b0);
      wait_idle();
      check("t4_dimes_after_partial", int'(bus.dime_count), 9);
      issue(0, "", 0, 1'b0, 1'b0);
      wait_idle();
      bus.refill_nickels = 1'b1;
      @(negedge clock);
      bus.refill_nickels = 1'b0;
      @(negedge clock);
      check("t4_nickels_refilled", int'(bus.nickel_count), 10);

      // Jam: no ack ever, dime_eject held for the full timeout
      ack_en = 1'b0;
      issue(2, "D", 0, 1'b1, 1'b1);
      wait_dime_eject();
      check("t5_busy_not_ready", int'(bus.refund_ready), 0);
      cnt = 0;
      while (bus.dime_eject && cnt < 200) begin
         cnt++;
         @(negedge clock);
      end
      check("t5_eject_cycles", cnt, 64);
      wait_idle();
      ack_en = 1'b1;
      check("t5_dimes_unchanged", int'(bus.dime_count), 9);

      // Refill coinciding with the dime ack, then saturation
      do_reset();
      check("t6_rst_dimes", int'(bus.dime_count), 20);
      issue(2, "D", 2, 1'b0, 1'b0);
      wait_dime_eject();
      bus.refill_dimes = 1'b1;
      @(negedge clock);
      bus.refill_dimes = 1'b0;
      wait_idle();
      check("t6_refill_and_take", int'(bus.dime_count), 29);
      bus.refill_dimes = 1'b1;
      repeat (30) @(negedge clock);
      bus.refill_dimes = 1'b0;
      @(negedge clock);
      check("t6_saturate", int'(bus.dime_count), 255);

      // Reset in the middle of an eject abandons the refund
      ack_en = 1'b0;
      issue(2, "D", 0, 1'b0, 1'b0);
      wait_dime_eject();
      reset_n = 1'b0;
      @(negedge clock);
      check("t6_mid_rst_dime_eject", int'(bus.dime_eject), 0);
      check("t6_mid_rst_nickel_eject", int'(bus.nickel_eject), 0);
      check("t6_mid_rst_done", int'(bus.done), 0);
      exp_res.delete();
      exp_coin.delete();
      @(negedge clock);
      reset_n = 1'b1;
      ack_en  = 1'b1;
      repeat (10) @(negedge clock);
      check("t6_mid_rst_nickels", int'(bus.nickel_count), 20);
      check("t6_mid_rst_dimes", int'(bus.dime_count), 20);
      check("t6_mid_rst_ready", int'(bus.refund_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
